branch_predictor_2lvl: RTL and testbench
========================================

Name: branch_predictor_2lvl

Overview:
- Parametrised successor to the single-table predictor in the pipelined RAT CPU.
- N-bit saturating-counter pattern history table (PHT), indexed bimodally or gshare-style from an optional global history register (GHR).
- Combinational lookup on the fetch-stage PC; registered update from the execute stage when a branch resolves.
- Saturating mispredict counter for performance monitoring.

Parameters:
- ADDR_W, 10: PC width in bits.
- ENTRIES, 64: number of PHT entries; power of two, at least 2. IDX_W = log2(ENTRIES).
- CNT_W, 2: counter width, 1 to 4.
- GHR_W, 0: global history length. 0 gives bimodal indexing; if greater than 0 it must be at most IDX_W.
- STAT_W, 16: width of the mispredict counter.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- lookup_pc  in  ADDR_W  fetch-stage PC
- pred_taken  out  1  predicted direction for lookup_pc
- pred_hit  out  1  a BTB entry matches (tied 1 without the BTB)
- pred_target  out  ADDR_W  predicted target (tied 0 without the BTB)
- upd_valid  in  1  a branch resolved in execute this cycle
- upd_pc  in  ADDR_W  PC of the resolved branch
- upd_taken  in  1  actual branch outcome
- upd_target  in  ADDR_W  actual branch destination
- upd_mispredict  in  1  resolved outcome differed from the prediction
- ghr_out  out  max(GHR_W,1)  current history, for debug
- mispredict_cnt  out  STAT_W  saturating mispredict count

Behaviour:
- Interface: reset rst, synchronous, active-high; clock clk.
- Index function:
  - idx(pc) = pc[IDX_W-1:0] XOR {zeros, ghr}.
  - When GHR_W = 0 there is no XOR term.
- Lookup is purely combinational, with zero latency.
  - pred_taken = MSB of PHT[idx(lookup_pc)], ANDed with pred_hit.
- Update happens on the posedge where upd_valid = 1. Let i = idx(upd_pc), computed with the GHR value held before that edge.
  - If upd_taken = 1 and PHT[i] is below 2^CNT_W-1, PHT[i] increments.
  - If upd_taken = 0 and PHT[i] is above 0, PHT[i] decrements.
  - Counters saturate at both ends and never wrap.
  - GHR <= {ghr[GHR_W-2:0], upd_taken}, so the newest outcome is in the LSB. The GHR is non-speculative: it changes only on resolve.
  - If upd_mispredict = 1 and mispredict_cnt is below all-ones, mispredict_cnt increments; it holds at all-ones.
- When upd_valid = 0, all state holds. upd_mispredict is ignored without upd_valid.
- Lookup and update in the same cycle to the same index:
  - The lookup returns the pre-update value; there is no bypass.
  - The new value is visible from the next cycle.
- Reset, including when asserted mid-stream with upd_valid = 1:
  - All PHT entries go to weakly-not-taken, 2^(CNT_W-1)-1. For CNT_W = 1 this is 0.
  - GHR, mispredict_cnt and all BTB valid bits go to 0. Reset wins over the update.
  - Outputs after reset: pred_taken = 0, ghr_out = 0, mispredict_cnt = 0, pred_target = 0. pred_hit = 0 with the BTB and 1 without.
- The PHT is a register array, not block RAM, so reset clears it in a single cycle.

Optional Feature:
- Macro: BRANCH_PRED_BTB_EN.
- With BRANCH_PRED_BTB_EN defined:
  - The block adds a direct-mapped BTB, indexed by upd_pc[IDX_W-1:0] and NOT GHR-hashed.
  - Each entry holds valid, tag = pc[ADDR_W-1:IDX_W], and target.
  - On an update with upd_taken = 1, the entry is written: valid = 1, tag, target = upd_target.
  - pred_hit = valid AND tag match for lookup_pc.
  - pred_target = the stored target.
- Without BRANCH_PRED_BTB_EN:
  - pred_hit = 1 and pred_target = 0.
  - The CPU takes the target from instruction bits [12:3], as it does today.

Decomposition:
- Package bpred_pkg holds:
  - localparam function clog2;
  - weak-not-taken init function;
  - typedef btb_entry_t {valid, tag, target}.
- One sub-module, sat_counter: CNT_W-wide, with inputs inc and en and a reset init value. The PHT instantiates one sat_counter per entry via generate.

Test Plan (ENTRIES=64, CNT_W=2, GHR_W=0 unless noted):
- Reset: after a reset pulse, lookup 0x000 and then 0x3FF -> pred_taken = 0 for both, mispredict_cnt = 0.
- Training: 2 taken updates at 0x012 -> pred_taken = 1 for lookup 0x012. After 5 taken plus 1 not-taken -> still 1 (counter at 2). After 2 more not-taken -> 0.
- Aliasing (BTB off): train 0x012 taken twice -> lookup 0x052 (same index 0x12) gives pred_taken = 1.
- Aliasing (BTB on): same training -> lookup 0x052 gives pred_hit = 0 and pred_taken = 0; lookup 0x012 gives pred_target = upd_target = 0x1A0.
- Gshare (GHR_W=4): updates taken, taken, not-taken, taken -> ghr_out = 4'b1101. A subsequent taken update at pc 0x000 increments entry 0x0D only.
- Same-cycle conflict: lookup 0x012 while updating 0x012 taken from state 1 -> pred_taken = 0 that cycle and 1 the next.
- Stats and reset: with STAT_W=4, 20 mispredicting updates -> mispredict_cnt = 0xF. Asserting rst in the same cycle as an update -> all state returns to its reset values.

Source files
------------

// File: rtl/bpred_pkg.sv
// Shared types and helpers for the two-level branch predictor.
// Holds the elaboration-time log2, the weakly-not-taken counter init value
// and the BTB entry layout used when BRANCH_PRED_BTB_EN is defined.
package bpred_pkg;

  // Upper bound for the BTB tag/target fields; ADDR_W must stay below this.
  localparam int BTB_FIELD_W = 32;

  // Ceiling log2, usable in localparam expressions.
  function automatic int clog2(input int value);
    int res;
    int rem;
    res = 0;
    rem = value - 1;
    while (rem > 0) begin
      res = res + 1;
      rem = rem >> 1;
    end
    return res;
  endfunction

  // Weakly-not-taken state: one below the taken threshold, 0 for 1-bit counters.
  function automatic int weak_not_taken(input int cnt_w);
    return (1 << (cnt_w - 1)) - 1;
  endfunction

  typedef struct packed {
    logic                   valid;
    logic [BTB_FIELD_W-1:0] tag;
    logic [BTB_FIELD_W-1:0] target;
  } btb_entry_t;

endpackage

// File: rtl/branch_predictor_2lvl_sat_counter.sv
// Up/down saturating counter with a configurable reset value.
// One instance per pattern-history-table entry.
module sat_counter #(
  parameter int               CNT_W = 2,
  parameter logic [CNT_W-1:0] INIT  = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Step toward the resolved direction, pinning at both ends instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= INIT;
    end else if (en) begin
      if (inc && (cnt != CNT_MAX)) begin
        cnt <= cnt + 1'b1;
      end else if (!inc && (cnt != '0)) begin
        cnt <= cnt - 1'b1;
      end
    end
  end

endmodule

// File: rtl/branch_predictor_2lvl.sv
// Two-level branch predictor: saturating-counter PHT indexed by PC, optionally
// XOR-hashed with a non-speculative global history register (GHR_W > 0).
// Lookup is combinational on the fetch PC; training happens on the clock edge
// where execute reports a resolved branch. No same-cycle bypass: a lookup that
// collides with an update sees the pre-update counter.
// Optional feature macro: BRANCH_PRED_BTB_EN adds a direct-mapped BTB
// (PC-indexed, never history-hashed) that supplies pred_hit/pred_target.
// Requires ADDR_W > log2(ENTRIES) and ADDR_W < 32.
module branch_predictor_2lvl
  import bpred_pkg::*;
#(
  parameter int ADDR_W  = 10,
  parameter int ENTRIES = 64,
  parameter int CNT_W   = 2,
  parameter int GHR_W   = 0,
  parameter int STAT_W  = 16
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [ADDR_W-1:0]                    lookup_pc,
  output logic                                 pred_taken,
  output logic                                 pred_hit,
  output logic [ADDR_W-1:0]                    pred_target,
  input  logic                                 upd_valid,
  input  logic [ADDR_W-1:0]                    upd_pc,
  input  logic                                 upd_taken,
  input  logic [ADDR_W-1:0]                    upd_target,
  input  logic                                 upd_mispredict,
  output logic [((GHR_W > 0) ? GHR_W : 1)-1:0] ghr_out,
  output logic [STAT_W-1:0]                    mispredict_cnt
);

  localparam int               IDX_W    = clog2(ENTRIES);
  localparam logic [CNT_W-1:0] PHT_INIT = CNT_W'(weak_not_taken(CNT_W));

  logic [IDX_W-1:0] ghr_hash;
  logic [IDX_W-1:0] lookup_idx;
  logic [IDX_W-1:0] upd_idx;
  logic [CNT_W-1:0] pht_cnt [ENTRIES];
  logic [CNT_W-1:0] lookup_cnt;
  logic             unused_bits;

  generate
    if (GHR_W > 0) begin : g_ghr
      logic [GHR_W-1:0] ghr;

      // Shift each resolved outcome in at the LSB; history moves only on resolve.
      always_ff @(posedge clk) begin
        if (rst) begin
          ghr <= '0;
        end else if (upd_valid) begin
          ghr <= GHR_W'({ghr, upd_taken});
        end
      end

      assign ghr_hash = IDX_W'(ghr);
      assign ghr_out  = ghr;
    end else begin : g_no_ghr
      assign ghr_hash = '0;
      assign ghr_out  = 1'b0;
    end
  endgenerate

  // Both ports hash with the same pre-edge history value.
  assign lookup_idx = lookup_pc[IDX_W-1:0] ^ ghr_hash;
  assign upd_idx    = upd_pc[IDX_W-1:0] ^ ghr_hash;

  generate
    for (genvar e = 0; e < ENTRIES; e++) begin : g_pht
      sat_counter #(
        .CNT_W (CNT_W),
        .INIT  (PHT_INIT)
      ) u_cnt (
        .clk (clk),
        .rst (rst),
        .en  (upd_valid && (upd_idx == IDX_W'(e))),
        .inc (upd_taken),
        .cnt (pht_cnt[e])
      );
    end
  endgenerate

  assign lookup_cnt = pht_cnt[lookup_idx];
  assign pred_taken = lookup_cnt[CNT_W-1] & pred_hit;

  // Performance counter: count resolved mispredicts, stick at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      mispredict_cnt <= '0;
    end else if (upd_valid && upd_mispredict && (mispredict_cnt != '1)) begin
      mispredict_cnt <= mispredict_cnt + 1'b1;
    end
  end

`ifdef BRANCH_PRED_BTB_EN
  localparam int TAG_W = ADDR_W - IDX_W;

  logic [ENTRIES-1:0] btb_valid;
  logic [TAG_W-1:0]   btb_tag [ENTRIES];
  logic [ADDR_W-1:0]  btb_tgt [ENTRIES];
  logic [IDX_W-1:0]   btb_lidx;
  logic [IDX_W-1:0]   btb_uidx;
  btb_entry_t         btb_rd;

  assign btb_lidx = lookup_pc[IDX_W-1:0];
  assign btb_uidx = upd_pc[IDX_W-1:0];

  // Taken branches allocate their slot; only the valid bits need clearing on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      btb_valid <= '0;
    end else if (upd_valid && upd_taken) begin
      btb_valid[btb_uidx] <= 1'b1;
    end
  end

  // Tag/target payload is qualified by the valid bits, so it carries no reset.
  always_ff @(posedge clk) begin
    if (upd_valid && upd_taken) begin
      btb_tag[btb_uidx] <= upd_pc[ADDR_W-1:IDX_W];
      btb_tgt[btb_uidx] <= upd_target;
    end
  end

  // Present the selected slot as one entry record.
  always_comb begin
    btb_rd        = '0;
    btb_rd.valid  = btb_valid[btb_lidx];
    btb_rd.tag    = BTB_FIELD_W'(btb_tag[btb_lidx]);
    btb_rd.target = BTB_FIELD_W'(btb_tgt[btb_lidx]);
  end

  assign pred_hit    = btb_rd.valid && (btb_rd.tag == BTB_FIELD_W'(lookup_pc[ADDR_W-1:IDX_W]));
  // Gate the payload so a miss (including straight after reset) reads as zero.
  assign pred_target = pred_hit ? ADDR_W'(btb_rd.target) : '0;
  assign unused_bits = ^{lookup_cnt, btb_rd.target[BTB_FIELD_W-1:ADDR_W]};
`else
  // Without a BTB every PC "hits"; the CPU decodes the target from the instruction.
  assign pred_hit    = 1'b1;
  assign pred_target = '0;
  assign unused_bits = ^{lookup_cnt, lookup_pc[ADDR_W-1:IDX_W], upd_pc[ADDR_W-1:IDX_W], upd_target};
`endif

endmodule

// File: tb/tb_branch_predictor_2lvl.sv
// Scoreboard bench for branch_predictor_2lvl. Two instances share stimulus:
// a bimodal one (GHR_W=0, STAT_W=4) and a gshare one (GHR_W=4, STAT_W=16).
// The driver predicts each cycle's outputs from an array-based model and
// queues them; the monitor compares on the falling edge.
module tb_branch_predictor_2lvl;

  localparam int ADDR_W  = 10;
  localparam int ENTRIES = 64;

  logic              clk;
  logic              rst;
  logic [ADDR_W-1:0] lookup_pc;
  logic              upd_valid;
  logic [ADDR_W-1:0] upd_pc;
  logic              upd_taken;
  logic [ADDR_W-1:0] upd_target;
  logic              upd_mispredict;

  logic              b_taken, b_hit;
  logic [ADDR_W-1:0] b_target;
  logic [0:0]        b_ghr;
  logic [3:0]        b_mcnt;
  logic              g_taken, g_hit;
  logic [ADDR_W-1:0] g_target;
  logic [3:0]        g_ghr;
  logic [15:0]       g_mcnt;

  branch_predictor_2lvl #(
    .ADDR_W(ADDR_W), .ENTRIES(ENTRIES), .CNT_W(2), .GHR_W(0), .STAT_W(4)
  ) u_bim (
    .clk(clk), .rst(rst), .lookup_pc(lookup_pc),
    .pred_taken(b_taken), .pred_hit(b_hit), .pred_target(b_target),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
    .upd_target(upd_target), .upd_mispredict(upd_mispredict),
    .ghr_out(b_ghr), .mispredict_cnt(b_mcnt)
  );

  branch_predictor_2lvl #(
    .ADDR_W(ADDR_W), .ENTRIES(ENTRIES), .CNT_W(2), .GHR_W(4), .STAT_W(16)
  ) u_gsh (
    .clk(clk), .rst(rst), .lookup_pc(lookup_pc),
    .pred_taken(g_taken), .pred_hit(g_hit), .pred_target(g_target),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
    .upd_target(upd_target), .upd_mispredict(upd_mispredict),
    .ghr_out(g_ghr), .mispredict_cnt(g_mcnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  int pht  [2][ENTRIES];
  int ghr  [2];
  int mcnt [2];
  int stat_max [2] = '{15, 65535};
  int hist_mod [2] = '{1, 16};
  bit btb_v   [ENTRIES];
  int btb_tag [ENTRIES];
  int btb_tgt [ENTRIES];

  typedef struct {
    bit taken0;
    bit taken1;
    bit hit;
    int target;
    int ghr1;
    int mc0;
    int mc1;
  } exp_t;

  exp_t sb[$];
  int   n_pass  = 0;
  int   n_total = 0;

  function automatic int midx(input int k, input int pc);
    return (pc % ENTRIES) ^ ghr[k];
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < ENTRIES; i++) pht[k][i] = 1;
      ghr[k]  = 0;
      mcnt[k] = 0;
    end
    for (int i = 0; i < ENTRIES; i++) btb_v[i] = 1'b0;
  endtask

  task automatic model_step(input bit r, input bit v, input int pc, input bit t,
                            input int tgt, input bit mis);
    int i;
    if (r) begin
      model_reset();
    end else if (v) begin
      for (int k = 0; k < 2; k++) begin
        i = midx(k, pc);
        if (t && pht[k][i] < 3) pht[k][i]++;
        else if (!t && pht[k][i] > 0) pht[k][i]--;
        ghr[k] = (ghr[k] * 2 + (t ? 1 : 0)) % hist_mod[k];
        if (mis && mcnt[k] < stat_max[k]) mcnt[k]++;
      end
      if (t) begin
        btb_v[pc % ENTRIES]   = 1'b1;
        btb_tag[pc % ENTRIES] = pc / ENTRIES;
        btb_tgt[pc % ENTRIES] = tgt;
      end
    end
  endtask

  // ---------------- driver ----------------
  task automatic drive(input bit r, input bit v, input int upc, input bit t,
                       input int tgt, input bit mis, input int lpc);
    exp_t e;
    int   li;
    @(posedge clk);
    #1;
    rst            = r;
    upd_valid      = v;
    upd_pc         = upc[ADDR_W-1:0];
    upd_taken      = t;
    upd_target     = tgt[ADDR_W-1:0];
    upd_mispredict = mis;
    lookup_pc      = lpc[ADDR_W-1:0];
    li = lpc % ENTRIES;
`ifdef BRANCH_PRED_BTB_EN
    e.hit    = btb_v[li] && (btb_tag[li] == lpc / ENTRIES);
    e.target = e.hit ? btb_tgt[li] : 0;
`else
    e.hit    = 1'b1;
    e.target = 0;
`endif
    e.taken0 = e.hit && (pht[0][midx(0, lpc)] >= 2);
    e.taken1 = e.hit && (pht[1][midx(1, lpc)] >= 2);
    e.ghr1   = ghr[1];
    e.mc0    = mcnt[0];
    e.mc1    = mcnt[1];
    sb.push_back(e);
    model_step(r, v, upc, t, tgt, mis);
  endtask

  task automatic look(input int lpc);
    drive(1'b0, 1'b0, 0, 1'b0, 0, 1'b0, lpc);
  endtask

  task automatic upd(input int upc, input bit t, input int tgt, input bit mis, input int lpc);
    drive(1'b0, 1'b1, upc, t, tgt, mis, lpc);
  endtask

  // ---------------- monitor ----------------
  task automatic chk(input string name, input int act, input int req);
    n_total++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("bim_taken",  int'(b_taken),  int'(e.taken0));
        chk("gsh_taken",  int'(g_taken),  int'(e.taken1));
        chk("bim_hit",    int'(b_hit),    int'(e.hit));
        chk("gsh_hit",    int'(g_hit),    int'(e.hit));
        chk("bim_target", int'(b_target), e.target);
        chk("gsh_target", int'(g_target), e.target);
        chk("bim_ghr",    int'(b_ghr),    0);
        chk("gsh_ghr",    int'(g_ghr),    e.ghr1);
        chk("bim_mcnt",   int'(b_mcnt),   e.mc0);
        chk("gsh_mcnt",   int'(g_mcnt),   e.mc1);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int pool [4] = '{'h012, 'h052, 'h3D2, 'h000};
    int upc, lpc;
    rst = 1'b1; upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0;
    upd_target = '0; upd_mispredict = 1'b0; lookup_pc = '0;
    model_reset();
    repeat (2) @(posedge clk);

    // Reset pulse, then lookups at both ends of the PC space.
    drive(1'b1, 1'b0, 0, 1'b0, 0, 1'b0, 'h000);
    look('h000);
    look('h3FF);

    // Training at 0x012, with a same-cycle lookup on the first update.
    upd('h012, 1'b1, 'h1A0, 1'b1, 'h012);
    upd('h012, 1'b1, 'h1A0, 1'b0, 'h012);
    look('h012);
    look('h052);
    repeat (3) upd('h012, 1'b1, 'h1A0, 1'b0, 'h3FF);
    upd('h012, 1'b0, 'h1A0, 1'b1, 'h012);
    look('h012);
    repeat (2) upd('h012, 1'b0, 'h1A0, 1'b1, 'h012);
    look('h012);

    // Aliasing / BTB: 0x052 shares index 0x12 with 0x012.
    drive(1'b1, 1'b0, 0, 1'b0, 0, 1'b0, 'h012);
    upd('h012, 1'b1, 'h1A0, 1'b0, 'h052);
    upd('h012, 1'b1, 'h1A0, 1'b0, 'h052);
    look('h052);
    look('h012);

    // Gshare history: T,T,N,T then a taken update at 0x000.
    drive(1'b1, 1'b0, 0, 1'b0, 0, 1'b0, 'h000);
    upd('h100, 1'b1, 'h010, 1'b0, 'h000);
    upd('h101, 1'b1, 'h020, 1'b0, 'h000);
    upd('h102, 1'b0, 'h030, 1'b0, 'h000);
    upd('h103, 1'b1, 'h040, 1'b0, 'h000);
    upd('h000, 1'b1, 'h050, 1'b0, 'h00D);
    look('h006);
    look('h000);
    look('h00D);

    // Mispredict counter saturation; mispredict without valid is ignored.
    drive(1'b1, 1'b0, 0, 1'b0, 0, 1'b0, 'h000);
    drive(1'b0, 1'b0, 'h020, 1'b1, 0, 1'b1, 'h020);
    repeat (20) upd('h020, 1'b1, 'h222, 1'b1, 'h020);
    look('h020);

    // Reset asserted together with an update: reset wins.
    drive(1'b1, 1'b1, 'h020, 1'b1, 'h111, 1'b1, 'h020);
    look('h020);
    look('h012);

    // Randomized traffic over a small aliasing-prone PC pool.
    for (int n = 0; n < 600; n++) begin
      upc = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 1023)) : pool[$urandom_range(0, 3)];
      lpc = ($urandom_range(0, 1) == 0) ? upc : pool[$urandom_range(0, 3)];
      drive(($urandom_range(0, 79) == 0), ($urandom_range(0, 3) != 0), upc,
            $urandom_range(0, 1), $urandom_range(0, 1023), $urandom_range(0, 1), lpc);
    end
    look('h012);

    for (int w = 0; w < 20 && sb.size() > 0; w++) @(posedge clk);
    if (sb.size() > 0) begin
      n_total++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
